// File: rtl/print_scheduler_if.sv
// Bundle between the print scheduler, its command requesters and the shared
// overlay draw engine. The slave modport is the scheduler's view.
interface print_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic                    eng_start;
    logic [DATA_W-1:0]       eng_data;
    logic                    eng_done;
    logic                    printting;
    logic [OWN_W-1:0]        owner;
    logic                    timeout_err;

    // Requesters and engine together form the master side.
    modport master (
        output req, req_data, eng_done,
        input  grant, eng_start, eng_data, printting, owner, timeout_err
    );

    modport slave (
        input  req, req_data, eng_done,
        output grant, eng_start, eng_data, printting, owner, timeout_err
    );
endinterface

// File: rtl/print_scheduler.sv
// Round-robin arbiter and job sequencer for the shared print engine:
// select a requester, launch it with a start pulse, then wait for done or time out.
module print_scheduler #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    print_scheduler_if.slave  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]   N_WIDE   = (PTR_W + 1)'(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic [PTR_W-1:0]    owner_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   eng_data_r;
    logic [N_REQ-1:0]    grant_r;
    logic                eng_start_r;
    logic                printting_r;

    logic                win_vld_s;
    logic [PTR_W-1:0]    win_idx_s;
    logic [PTR_W:0]      scan_sum_s;
    logic [PTR_W-1:0]    scan_idx_s;
    logic                scan_hit_s;
    logic                select_s;
    logic                timeout_hit_s;
    logic [PTR_W-1:0]    ptr_nxt_s;

    // Round-robin scan: first set request at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_vld_s  = 1'b0;
        win_idx_s  = '0;
        scan_sum_s = '0;
        scan_idx_s = '0;
        scan_hit_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum_s = {1'b0, rr_ptr_r} + (PTR_W + 1)'(i);
            scan_idx_s = (scan_sum_s >= N_WIDE) ? PTR_W'(scan_sum_s - N_WIDE)
                                                : PTR_W'(scan_sum_s);
            scan_hit_s = !win_vld_s && bus.req[scan_idx_s];
            win_idx_s  = scan_hit_s ? scan_idx_s : win_idx_s;
            win_vld_s  = win_vld_s | scan_hit_s;
        end
    end

    assign select_s      = (state_r == ST_IDLE) && win_vld_s;
    assign timeout_hit_s = (state_r == ST_WAIT) && (cnt_r == CNT_LAST);
    assign ptr_nxt_s     = (owner_r == PTR_MAX) ? '0 : owner_r + PTR_W'(1);

    // Next-state decode; done takes precedence over an expiring timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.eng_done || timeout_hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Launch outputs: grant and start are precomputed so they are high exactly during ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_start_r <= 1'b0;
            grant_r     <= '0;
            printting_r <= 1'b0;
        end else begin
            eng_start_r <= select_s;
            grant_r     <= select_s ? (N_REQ'(1) << win_idx_s) : '0;
            printting_r <= (state_nxt_s != ST_IDLE);
        end
    end

    // Command commit at selection; later req/req_data changes are ignored until the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_r    <= '0;
            eng_data_r <= '0;
        end else if (select_s) begin
            owner_r    <= win_idx_s;
            eng_data_r <= bus.req_data[int'(win_idx_s) * DATA_W +: DATA_W];
        end else begin
            owner_r    <= owner_r;
            eng_data_r <= eng_data_r;
        end
    end

    // Priority pointer moves past the winner once its job is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= '0;
        end else if (state_r == ST_ISSUE) begin
            rr_ptr_r <= ptr_nxt_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // WAIT-cycle counter, cleared on ISSUE so WAIT cycle k sees the value k-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.grant     = grant_r;
    assign bus.eng_start = eng_start_r;
    assign bus.eng_data  = eng_data_r;
    assign bus.printting = printting_r;
    assign bus.owner     = owner_r;
    // Decoded from registered state; gated by done so a same-cycle completion suppresses it.
    assign bus.timeout_err = timeout_hit_s && !bus.eng_done;

endmodule

// File: doc/print_scheduler.md
# print_scheduler

Arbitrates and sequences access to the single shared print (overlay draw) engine among several command requesters. A work-conserving round-robin arbiter picks one request, launches it on the engine with a start/done handshake and supervises it with a timeout. Its `printting` busy flag drives the 1-bit status PIO input that the Nios II software polls.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: command word width.
- `TIMEOUT_CYC`, 65535: maximum cycles to wait for `eng_done`, 2..65535.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  request per requester; held high until its grant.
- `req_data`  in  N_REQ*DATA_W  command words; requester i uses bits [i*DATA_W +: DATA_W], held stable while `req[i]` is high.
- `grant`  out  N_REQ  one-hot, one-cycle acknowledge to the winner.
- `eng_start`  out  1  one-cycle launch pulse to the engine.
- `eng_data`  out  DATA_W  registered command word to the engine.
- `eng_done`  in  1  one-cycle completion pulse from the engine.
- `printting`  out  1  busy flag to the status PIO.
- `owner`  out  clog2(N_REQ)  index of the last granted requester.
- `timeout_err`  out  1  one-cycle pulse on an aborted job.

## Operation
- Clock domain and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs are 0, the FSM is in IDLE, and the round-robin pointer `rr_ptr` is 0, so requester 0 has highest priority.
- FSM states:
  - IDLE: if `req` is nonzero, choose the first set bit scanning from `rr_ptr` upward with wrap-around modulo N_REQ. On that edge, register the winner into `owner` and its word into `eng_data`, then go to ISSUE. If `req` is zero, stay in IDLE.
  - ISSUE: one cycle. `eng_start`=1 and `grant[owner]`=1. `rr_ptr` becomes (owner+1) mod N_REQ. Go to WAIT with the timeout counter cleared to 0.
  - WAIT: the counter increments each cycle. If `eng_done`=1, go to IDLE. Otherwise, when the counter equals TIMEOUT_CYC-1, pulse `timeout_err` for one cycle and go to IDLE.
- `printting` = (state != IDLE), driven from a register.
- `eng_done` is ignored outside WAIT. If `eng_done` and the timeout fire in the same cycle, `eng_done` wins and there is no `timeout_err`.
- A requester that drops `req` after selection but before ISSUE is still granted and launched; the command is committed at selection.
- Requests and `eng_data` changes seen outside IDLE have no effect; `eng_data` holds its value until the next selection.
- Reset asserted mid-job returns all outputs to their reset values immediately. The engine is not notified; the system resets the engine on the same `reset_n`.
- `owner` keeps the last winner after the job ends.

## Timing
- Selection to `eng_start`: 1 cycle. The `req` edge seen in IDLE at cycle T gives `eng_start`/`grant` high during cycle T+1.
- `printting` rises in cycle T+1, together with `eng_start`. It falls the cycle after `eng_done` is sampled in WAIT.
- Back-to-back: with a request pending, the next ISSUE occurs 2 cycles after the `eng_done` cycle (the WAIT→IDLE edge, then the IDLE selection edge).
- Timeout: with no `eng_done`, `timeout_err` pulses in the TIMEOUT_CYC-th cycle of WAIT. `printting` is high for TIMEOUT_CYC+1 cycles (ISSUE plus WAIT).
- Exactly one `grant` bit is high, and only during ISSUE.

## Test plan
- Reset, then a single request: `reset_n` low, then `req`=0001 with `req_data[0]`=0xCAFE0001 → 1 cycle later `eng_start`=1, `grant`=0001, `eng_data`=0xCAFE0001, `printting`=1. Then `eng_done` after 5 WAIT cycles → `printting`=0 the next cycle.
- Round-robin fairness: hold `req`=1111 and answer every start with `eng_done` 3 cycles later → grant order 0,1,2,3,0,1; each grant is 2 cycles after the previous `eng_done`.
- Wrap and skip: `rr_ptr`=3 (after a grant to 2) and `req`=0101 → winner 0, then 2, and never 1 or 3.
- Timeout: TIMEOUT_CYC=8, with no `eng_done` → `timeout_err` is a single pulse in WAIT cycle 8, and `printting` is high for exactly 9 cycles. A following request is served normally.
- Collision: `eng_done` in the same cycle the counter reaches TIMEOUT_CYC-1 → no `timeout_err` and a normal return to IDLE. An `eng_done` injected during IDLE/ISSUE has no effect.
- Reset mid-job: `reset_n` pulsed low in WAIT → `printting`, `grant`, `eng_start`, `owner` and `eng_data` are all 0 asynchronously, and requester 0 wins the next arbitration.
